ps2_keycode_rx: RTL

PS/2 keyboard front end that turns the raw ps2_clk/ps2_data lines into 9-bit key codes. Bit 8 of the code flags an E0-extended key. Output is a single-cycle kc_valid strobe with key_code held stable afterwards, which is the format the key-count/display stage consumes. The block covers synchronisation, glitch filtering, 11-bit frame reception with parity check, idle timeout, and scan-code set 2 prefix handling (E0, F0).

---
 rtl/ps2_keycode_rx.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_keycode_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ps2_keycode_rx                                               |
// | Description : PS/2 keyboard receiver. Synchronises and glitch-filters the  |
// |               raw PS/2 lines, receives 11-bit frames (start, 8 data LSB    |
// |               first, odd parity, stop), discards stalled frames after an   |
// |               idle timeout and folds scan-code set 2 prefixes (E0, F0)     |
// |               into 9-bit key codes {extended, scan byte}.                  |
// | Ports       : clk, resetn      - clock, synchronous active-low reset       |
// |               ps2_clk/ps2_data - raw asynchronous PS/2 lines               |
// |               key_code         - {ext, byte}, held between strobes         |
// |               kc_valid         - 1-cycle strobe, key_code/key_release new  |
// |               key_release      - key_code is a break event                 |
// |               rx_error         - 1-cycle strobe on parity/stop/timeout     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ps2_keycode_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int REPORT_BREAKS  = 0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [8:0] key_code,
  output logic       kc_valid,
  output logic       key_release,
  output logic       rx_error
);

  localparam int C_FCNT_W = $clog2(FILTER_LEN + 1);
  localparam int C_TCNT_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // Index 0 = ps2_clk, index 1 = ps2_data.
  logic [1:0] w_raw;
  logic [1:0] w_filt;

  assign w_raw = {ps2_data, ps2_clk};

  // Per line: 2-FF synchroniser followed by a level filter that only
  // follows the synchronised value once it has differed for FILTER_LEN
  // consecutive cycles.
  for (genvar i = 0; i < 2; i++) begin : g_line
    logic                sync1_q;
    logic                sync2_q;
    logic                filt_q;
    logic [C_FCNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
      if (!resetn) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
        filt_q  <= 1'b1;
        cnt_q   <= '0;
      end else begin
        sync1_q <= w_raw[i];
        sync2_q <= sync1_q;
        if (sync2_q == filt_q) begin
          cnt_q <= '0;
        end else if (cnt_q == C_FCNT_W'(FILTER_LEN - 1)) begin
          filt_q <= sync2_q;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign w_filt[i] = filt_q;
  end

  state_t              state_q;
  logic [2:0]          bit_cnt_q;
  logic [7:0]          shift_q;
  logic                par_q;
  logic [C_TCNT_W-1:0] tmo_q;
  logic                fclk_prev_q;
  logic                ext_q;
  logic                brk_q;
  logic [8:0]          key_code_q;
  logic                kc_valid_q;
  logic                key_release_q;
  logic                rx_error_q;

  logic w_sample;
  logic w_data;
  logic w_tmo_hit;
  logic w_byte_ok;

  assign w_sample  = fclk_prev_q & ~w_filt[0];
  assign w_data    = w_filt[1];
  assign w_tmo_hit = (state_q != S_IDLE) && (tmo_q == C_TCNT_W'(TIMEOUT_CYCLES - 1));
  // Good frame: stop bit high and odd parity over data plus parity bit.
  assign w_byte_ok = w_data & (^{shift_q, par_q});

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      par_q         <= 1'b0;
      tmo_q         <= '0;
      fclk_prev_q   <= 1'b1;
      ext_q         <= 1'b0;
      brk_q         <= 1'b0;
      key_code_q    <= '0;
      kc_valid_q    <= 1'b0;
      key_release_q <= 1'b0;
      rx_error_q    <= 1'b0;
    end else begin
      fclk_prev_q <= w_filt[0];
      kc_valid_q  <= 1'b0;
      rx_error_q  <= 1'b0;
      // A sample event takes precedence over a coincident timeout.
      if (w_sample) begin
        tmo_q <= '0;
        case (state_q)
          S_IDLE: begin
            if (!w_data) begin
              state_q   <= S_DATA;
              bit_cnt_q <= '0;
            end
          end
          S_DATA: begin
            shift_q   <= {w_data, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= S_PARITY;
            end
          end
          S_PARITY: begin
            par_q   <= w_data;
            state_q <= S_STOP;
          end
          S_STOP: begin
            state_q <= S_IDLE;
            if (!w_byte_ok) begin
              rx_error_q <= 1'b1;
              ext_q      <= 1'b0;
              brk_q      <= 1'b0;
            end else if (shift_q == 8'hE0) begin
              ext_q <= 1'b1;
            end else if (shift_q == 8'hF0) begin
              brk_q <= 1'b1;
            end else begin
              ext_q <= 1'b0;
              brk_q <= 1'b0;
              // Suppressed releases leave the held code untouched.
              if (!brk_q || (REPORT_BREAKS != 0)) begin
                key_code_q    <= {ext_q, shift_q};
                key_release_q <= brk_q;
                kc_valid_q    <= 1'b1;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end else if (w_tmo_hit) begin
        state_q    <= S_IDLE;
        tmo_q      <= '0;
        rx_error_q <= 1'b1;
        ext_q      <= 1'b0;
        brk_q      <= 1'b0;
      end else if (state_q != S_IDLE) begin
        tmo_q <= tmo_q + 1'b1;
      end else begin
        tmo_q <= '0;
      end
    end
  end

  assign key_code    = key_code_q;
  assign kc_valid    = kc_valid_q;
  assign key_release = key_release_q;
  assign rx_error    = rx_error_q;

endmodule
`default_nettype wire
